// File: rtl/poa_pkg.sv
// Shared types for the proof-of-authority block proposer and its request FIFO.
package poa_pkg;

  localparam int ID_W = 32;

  typedef logic [ID_W-1:0] poa_id_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    REPORT
  } poa_prop_state_t;

endpackage

// File: rtl/poa_req_fifo.sv
// Request FIFO holding {block_id, validator_id} pairs awaiting validation.
module poa_req_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/poa_block_proposer.sv
// Queues candidate blocks and issues them one at a time to the proof-of-authority
// validator, reporting each verdict upstream and keeping accept/reject statistics.
//
// state  | meaning
// IDLE   | waiting for a queued block; pops the FIFO head into the request regs
// ISSUE  | validate_block pulse to the validator
// WAIT   | counting down to the block_valid sample point
// REPORT | result_valid strobe; statistics updated
module poa_block_proposer
  import poa_pkg::*;
#(
  parameter int ID_W     = poa_pkg::ID_W,
  parameter int DEPTH    = 4,
  parameter int RESP_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             submit_valid,
  output logic             submit_ready,
  input  logic [ID_W-1:0]  submit_block_id,
  input  logic [ID_W-1:0]  submit_validator_id,
  output logic             validate_block,
  output logic [ID_W-1:0]  block_id,
  output logic [ID_W-1:0]  validator_id,
  input  logic             block_valid,
  output logic             result_valid,
  output logic [ID_W-1:0]  result_block_id,
  output logic             result_accepted,
  output logic [CNT_W-1:0] accepted_count,
  output logic [CNT_W-1:0] rejected_count,
  output logic             busy
);

  localparam int WCW = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(RESP_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  poa_prop_state_t   state_q;
  logic [WCW-1:0]    wait_cnt;
  logic              ready_en;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [2*ID_W-1:0] fifo_head;

  // Hold submit_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  assign submit_ready = ready_en && !fifo_full;
  assign fifo_pop     = (state_q == IDLE) && !fifo_empty;
  assign busy         = (state_q != IDLE) || !fifo_empty;

  poa_req_fifo #(
    .W     (2*ID_W),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst_n     (reset_n),
    .push      (submit_valid && submit_ready),
    .push_data ({submit_block_id, submit_validator_id}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      wait_cnt        <= '0;
      validate_block  <= 1'b0;
      block_id        <= '0;
      validator_id    <= '0;
      result_valid    <= 1'b0;
      result_block_id <= '0;
      result_accepted <= 1'b0;
      accepted_count  <= '0;
      rejected_count  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            block_id       <= fifo_head[2*ID_W-1:ID_W];
            validator_id   <= fifo_head[ID_W-1:0];
            validate_block <= 1'b1;
            state_q        <= ISSUE;
          end
        end
        ISSUE: begin
          validate_block <= 1'b0;
          wait_cnt       <= '0;
          state_q        <= WAIT;
        end
        WAIT: begin
          // block_valid is only looked at on this one cycle.
          if (wait_cnt == WAIT_LAST) begin
            result_accepted <= block_valid;
            result_block_id <= block_id;
            result_valid    <= 1'b1;
            state_q         <= REPORT;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        REPORT: begin
          result_valid <= 1'b0;
          if (result_accepted) begin
            if (accepted_count != CNT_MAX) begin
              accepted_count <= accepted_count + CNT_W'(1);
            end
          end else begin
            if (rejected_count != CNT_MAX) begin
              rejected_count <= rejected_count + CNT_W'(1);
            end
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
